// File: rtl/t_to_jk_ff_pkg.sv
// Shared types and helpers for the JK-from-T flip-flop slice.
// Names the four JK operations and provides the per-bit J/K -> T excitation.
package t_to_jk_ff_pkg;

  localparam int DEFAULT_WIDTH = 1;

  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_CLEAR  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_op_e;

  // Decode a J/K pair into the operation it requests.
  function automatic jk_op_e jk_decode(input logic j, input logic k);
    jk_op_e op;
    case ({j, k})
      2'b00:   op = JK_HOLD;
      2'b01:   op = JK_CLEAR;
      2'b10:   op = JK_SET;
      2'b11:   op = JK_TOGGLE;
      default: op = JK_HOLD;
    endcase
    return op;
  endfunction

  // Toggle request that makes a T flop behave as JK, given the pre-edge state.
  function automatic logic jk_to_t(input logic j, input logic k, input logic q);
    return (j & ~q) | (k & q);
  endfunction

endpackage

// File: rtl/t_to_jk_ff_if.sv
// J/K inputs and Q/Qbar outputs of the JK flip-flop, grouped as one bundle.
interface t_to_jk_ff_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] J;
  logic [WIDTH-1:0] K;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Qbar;

  modport master (output J, output K, input Q, input Qbar);
  modport slave  (input J, input K, output Q, output Qbar);
endinterface

// File: rtl/t_to_jk_ff_t_ff.sv
// Generic WIDTH-wide toggle register with synchronous active-high reset.
module t_ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] T,
  output logic [WIDTH-1:0] Q
);

  localparam logic [WIDTH-1:0] RESET_VALUE = '0;

  logic [WIDTH-1:0] q_r;

  // Toggle state register; reset takes priority over any toggle request.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r <= RESET_VALUE;
    end else begin
      q_r <= q_r ^ T;
    end
  end

  assign Q = q_r;

endmodule

// File: rtl/t_to_jk_ff.sv
// JK flip-flop: J/K excitation logic drives a toggle register; Qbar is ~Q.
module t_to_jk_ff
  import t_to_jk_ff_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic          clk,
  input logic          reset,
  t_to_jk_ff_if.slave  bus
);

  logic [WIDTH-1:0] t_s;
  logic [WIDTH-1:0] q_s;

  // Per-bit excitation from J/K and the current registered state.
  always_comb begin
    t_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      t_s[i] = jk_to_t(bus.J[i], bus.K[i], q_s[i]);
    end
  end

  t_ff #(
    .WIDTH (WIDTH)
  ) u_t_ff (
    .clk   (clk),
    .reset (reset),
    .T     (t_s),
    .Q     (q_s)
  );

  assign bus.Q    = q_s;
  assign bus.Qbar = ~q_s;

endmodule

// File: tb/tb_t_to_jk_ff.sv
// Self-checking bench for t_to_jk_ff (WIDTH=4): directed table, corner sequences
// and a random run, all checked through an expected-value queue.
module tb_t_to_jk_ff;
  import t_to_jk_ff_pkg::*;

  localparam int W = 4;

  typedef struct packed {
    logic         rst;
    logic [W-1:0] j;
    logic [W-1:0] k;
    logic [W-1:0] exp_q;
  } vec_t;

  logic clk;
  logic reset;
  t_to_jk_ff_if #(.WIDTH(W)) bus ();

  t_to_jk_ff #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] exp_q_queue[$];
  logic [W-1:0] model_q;
  int           n_tests;
  int           n_fail;

  // Independent JK behaviour model, one bit at a time.
  function automatic logic [W-1:0] jk_model(input logic rst, input logic [W-1:0] q,
                                            input logic [W-1:0] j, input logic [W-1:0] k);
    logic [W-1:0] nq;
    nq = q;
    for (int b = 0; b < W; b++) begin
      case (jk_decode(j[b], k[b]))
        JK_HOLD:   nq[b] = q[b];
        JK_CLEAR:  nq[b] = 1'b0;
        JK_SET:    nq[b] = 1'b1;
        JK_TOGGLE: nq[b] = ~q[b];
        default:   nq[b] = q[b];
      endcase
    end
    if (rst) nq = '0;
    return nq;
  endfunction

  // Drive one cycle, queue the expectation, then check Q/Qbar after the edge.
  task automatic step(input string name, input logic rst, input logic [W-1:0] j,
                      input logic [W-1:0] k, input logic [W-1:0] exp_q);
    logic [W-1:0] e;
    @(negedge clk);
    reset = rst;
    bus.J = j;
    bus.K = k;
    exp_q_queue.push_back(exp_q);
    @(posedge clk);
    #1;
    e = exp_q_queue.pop_front();
    n_tests++;
    if (bus.Q !== e) begin
      n_fail++;
      $display("FAIL %s Q: got %b expected %b", name, bus.Q, e);
    end
    n_tests++;
    if (bus.Qbar !== ~e) begin
      n_fail++;
      $display("FAIL %s Qbar: got %b expected %b", name, bus.Qbar, ~e);
    end
  endtask

  vec_t vecs[$];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    bus.J   = '0;
    bus.K   = '0;

    // reset, hold, set/clear, toggle, mid-toggle reset, mixed-bit vector
    vecs.push_back('{1'b1, 4'hF, 4'hF, 4'h0});
    vecs.push_back('{1'b0, 4'h0, 4'h0, 4'h0});
    vecs.push_back('{1'b0, 4'h0, 4'h0, 4'h0});
    vecs.push_back('{1'b0, 4'h0, 4'h0, 4'h0});
    vecs.push_back('{1'b0, 4'hF, 4'h0, 4'hF});
    vecs.push_back('{1'b0, 4'h0, 4'h0, 4'hF});
    vecs.push_back('{1'b0, 4'h0, 4'h0, 4'hF});
    vecs.push_back('{1'b0, 4'h0, 4'hF, 4'h0});
    vecs.push_back('{1'b0, 4'hF, 4'h0, 4'hF});
    vecs.push_back('{1'b0, 4'h0, 4'hF, 4'h0});
    vecs.push_back('{1'b0, 4'hF, 4'hF, 4'hF});
    vecs.push_back('{1'b0, 4'hF, 4'hF, 4'h0});
    vecs.push_back('{1'b0, 4'hF, 4'hF, 4'hF});
    vecs.push_back('{1'b0, 4'hF, 4'hF, 4'h0});
    vecs.push_back('{1'b0, 4'hF, 4'hF, 4'hF});
    vecs.push_back('{1'b1, 4'hF, 4'hF, 4'h0});
    vecs.push_back('{1'b0, 4'hF, 4'hF, 4'hF});
    vecs.push_back('{1'b1, 4'h0, 4'h0, 4'h0});
    vecs.push_back('{1'b0, 4'b0011, 4'b1100, 4'b0011});
    vecs.push_back('{1'b0, 4'b1010, 4'b0110, 4'b1001});

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].j, vecs[i].k, vecs[i].exp_q);
    end

    // Reset held across several edges while J/K request set, then release.
    step("rst_hold0", 1'b1, 4'hF, 4'h0, 4'h0);
    step("rst_hold1", 1'b1, 4'hF, 4'h0, 4'h0);
    step("rst_release", 1'b0, 4'hF, 4'h0, 4'hF);

    // Random per-bit J/K with occasional reset against the behavioural model.
    model_q = 4'hF;
    for (int i = 0; i < 40; i++) begin
      logic         r;
      logic [W-1:0] j;
      logic [W-1:0] k;
      r = ($urandom_range(0, 9) == 0);
      j = W'($urandom);
      k = W'($urandom);
      model_q = jk_model(r, model_q, j, k);
      step($sformatf("rand%0d", i), r, j, k, model_q);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
